// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: iterative unsigned MUL/MULHU/DIVU/REMU unit beside the EX ALU.
// Runs one radix-2 step per cycle (shift-add multiply or restoring divide) and
// holds the pipeline with EX_stall while an operation is in flight.
// Ports:
//   clk, reset (sync, active-low)
//   start, op, rs1_data, rs2_data, rd : operation request, sampled on accept
//   EX_kick_up                        : flush, aborts any operation in flight
//   EX_stall (combinational), busy, done, result, result_rd : status and result
module ex_muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            EX_kick_up,
  output logic            EX_stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_DIVU = 2'd2;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  // a_q: multiplicand or divisor; hi_q: product high half or remainder;
  // lo_q: multiplier (shifted out) or dividend (shifted out, quotient shifted in)
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;

  logic [XLEN:0]    add_sum;
  logic [XLEN:0]    rem_shift;
  logic             rem_ge;
  logic [XLEN-1:0]  step_hi;
  logic [XLEN-1:0]  step_lo;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             div_zero;

  // One iteration of the shared datapath; op_q[1] selects divide.
  always_comb begin
    add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    rem_shift = {hi_q, lo_q[XLEN-1]};
    rem_ge    = (rem_shift >= {1'b0, a_q});
    step_hi   = add_sum[XLEN:1];
    step_lo   = {add_sum[0], lo_q[XLEN-1:1]};
    if (op_q[1]) begin
      // A failed trial subtract always leaves rem_shift below 2^XLEN.
      step_hi = rem_ge ? XLEN'(rem_shift - {1'b0, a_q}) : rem_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], rem_ge};
    end
  end

  assign cnt_next = counter + CNT_W'(1);
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign div_zero = op[1] && (rs2_data == '0);

  // Any accepted start finishes at the earliest one edge later, so it always stalls.
  assign EX_stall = !EX_kick_up && ((state == RUN) || accept);

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_rd <= '0;
    end else if (EX_kick_up) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (accept) begin
            op_q    <= op;
            rd_q    <= rd;
            counter <= '0;
            hi_q    <= '0;
            if (op[1]) begin
              a_q  <= rs2_data;
              lo_q <= rs1_data;
            end else begin
              a_q  <= rs1_data;
              lo_q <= rs2_data;
            end
            if (div_zero) begin
              state     <= DONE;
              done      <= 1'b1;
              result    <= (op == OP_DIVU) ? '1 : rs1_data;
              result_rd <= rd;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          counter <= cnt_next;
          hi_q    <= step_hi;
          lo_q    <= step_lo;
          if (cnt_next == CNT_W'(XLEN)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            // MULHU and REMU take the high register, MUL and DIVU the low one.
            result    <= op_q[0] ? step_hi : step_lo;
            result_rd <= rd_q;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed self-checking bench for ex_muldiv_sequencer.
module tb_ex_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        EX_kick_up;
  logic        EX_stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int checks = 0;
  int errors = 0;
  int lat;
  int stl;
  int dcount;

  ex_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
    .EX_kick_up(EX_kick_up), .EX_stall(EX_stall), .busy(busy),
    .done(done), .result(result), .result_rd(result_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation at a negedge; returns at the negedge where done is seen.
  // lat counts edges from the start cycle to done, stl counts stalled cycles.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit scramble);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd = r;
    lat = 0; stl = 0;
    do begin
      #1;
      if (EX_stall) stl++;
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (scramble) begin
        rs1_data = $urandom;
        rs2_data = $urandom;
        op = 2'($urandom_range(0, 3));
      end
    end while (!done && lat < 100);
  endtask

  task automatic count_done(input int cycles);
    dcount = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'd0; rs1_data = '0; rs2_data = '0;
    rd = '0; EX_kick_up = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(EX_stall), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(result_rd), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // MUL 7 x 6
    issue(2'd0, 32'd7, 32'd6, 5'd5, 1'b0);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul_stall_cycles", 32'(stl), 32'd33);
    chk("mul_done", 32'(done), 32'd1);
    chk("mul_result", result, 32'h0000_002A);
    chk("mul_rd", 32'(result_rd), 32'd5);
    chk("mul_done_busy", 32'(busy), 32'd0);
    chk("mul_done_stall", 32'(EX_stall), 32'd0);
    @(negedge clk);
    chk("mul_done_pulse", 32'(done), 32'd0);
    chk("mul_result_hold", result, 32'h0000_002A);

    // MULHU then back-to-back DIVU issued in the DONE cycle
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0);
    chk("mulhu_result", result, 32'hFFFF_FFFE);
    chk("mulhu_rd", 32'(result_rd), 32'd9);
    issue(2'd2, 32'd100, 32'd7, 5'd10, 1'b0);
    chk("b2b_divu_lat", 32'(lat), 32'd33);
    chk("b2b_divu_stall", 32'(stl), 32'd33);
    chk("b2b_divu_result", result, 32'h0000_000E);
    chk("b2b_divu_rd", 32'(result_rd), 32'd10);
    @(negedge clk);

    issue(2'd3, 32'd100, 32'd7, 5'd11, 1'b0);
    chk("remu_result", result, 32'h0000_0002);
    @(negedge clk);

    // Divide by zero
    issue(2'd2, 32'h0000_1234, 32'd0, 5'd12, 1'b0);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_stall", 32'(stl), 32'd1);
    chk("div0_q", result, 32'hFFFF_FFFF);
    chk("div0_rd", 32'(result_rd), 32'd12);
    @(negedge clk);
    chk("div0_pulse", 32'(done), 32'd0);
    issue(2'd3, 32'h0000_1234, 32'd0, 5'd13, 1'b0);
    chk("rem0_lat", 32'(lat), 32'd1);
    chk("rem0_r", result, 32'h0000_1234);
    @(negedge clk);

    // Boundary operands
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 1'b0);
    chk("mul_max_lo", result, 32'h0000_0001);
    @(negedge clk);
    issue(2'd2, 32'hFFFF_FFFF, 32'd1, 5'd15, 1'b0);
    chk("divu_by1", result, 32'hFFFF_FFFF);
    @(negedge clk);
    issue(2'd3, 32'h8000_0000, 32'd3, 5'd16, 1'b0);
    chk("remu_msb", result, 32'h0000_0002);
    @(negedge clk);

    // Flush with start in the same IDLE cycle drops the start
    start = 1'b1; op = 2'd0; rs1_data = 32'd2; rs2_data = 32'd2; rd = 5'd1;
    EX_kick_up = 1'b1;
    #1 chk("kick_start_stall", 32'(EX_stall), 32'd0);
    @(negedge clk);
    start = 1'b0; EX_kick_up = 1'b0;
    #1 chk("kick_start_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Flush on RUN cycle 10
    start = 1'b1; op = 2'd2; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_kick_busy", 32'(busy), 32'd1);
    EX_kick_up = 1'b1;
    #1 chk("kick_stall_forced", 32'(EX_stall), 32'd0);
    @(negedge clk);
    EX_kick_up = 1'b0;
    #1;
    chk("kick_busy", 32'(busy), 32'd0);
    chk("kick_stall", 32'(EX_stall), 32'd0);
    chk("kick_done", 32'(done), 32'd0);
    count_done(40);
    chk("kick_no_done", 32'(dcount), 32'd0);
    chk("kick_result_hold", result, 32'h0000_0002);
    issue(2'd0, 32'd3, 32'd4, 5'd7, 1'b0);
    chk("post_kick_lat", 32'(lat), 32'd33);
    chk("post_kick_mul", result, 32'd12);
    chk("post_kick_rd", 32'(result_rd), 32'd7);
    @(negedge clk);

    // Synchronous reset on RUN cycle 20
    start = 1'b1; op = 2'd0; rs1_data = 32'd5; rs2_data = 32'd5; rd = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd1);
    chk("rst_async_result", result, 32'd12);
    @(negedge clk);
    chk("rst_run_busy", 32'(busy), 32'd0);
    chk("rst_run_done", 32'(done), 32'd0);
    chk("rst_run_result", result, 32'd0);
    chk("rst_run_rd", 32'(result_rd), 32'd0);
    chk("rst_run_stall", 32'(EX_stall), 32'd0);
    reset = 1'b1;
    count_done(40);
    chk("rst_no_done", 32'(dcount), 32'd0);

    // Inputs scrambled every cycle during RUN
    issue(2'd0, 32'h0000_1234, 32'h0000_5678, 5'd20, 1'b1);
    chk("scr_mul", result, 32'h0626_0060);
    chk("scr_mul_rd", 32'(result_rd), 32'd20);
    @(negedge clk);
    issue(2'd2, 32'd1000, 32'd3, 5'd21, 1'b1);
    chk("scr_divu", result, 32'h0000_014D);
    @(negedge clk);
    issue(2'd3, 32'd1000, 32'd3, 5'd22, 1'b1);
    chk("scr_remu", result, 32'h0000_0001);
    chk("scr_remu_lat", 32'(lat), 32'd33);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
